// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with valid/ready handshake, flush and optional skid entry (macro ID_EX_PIPE_SKID_EN)
module id_ex_pipe #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 4,
   parameter int CTRL_W  = 8,
   parameter int RA_W    = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               flush,
   input  logic [XLEN-1:0]    pc4_in,
   input  logic [XLEN-1:0]    rd1_in,
   input  logic [XLEN-1:0]    rd2_in,
   input  logic [XLEN-1:0]    imm_in,
   input  logic               alusrc_in,
   input  logic [ALUOP_W-1:0] aluop_in,
   input  logic [CTRL_W-1:0]  ctrl_in,
   input  logic [RA_W-1:0]    rd_in,
   output logic [XLEN-1:0]    pc4_out,
   output logic [XLEN-1:0]    a_out,
   output logic [XLEN-1:0]    b_out,
   output logic [XLEN-1:0]    imm_out,
   output logic               alusrc_out,
   output logic [ALUOP_W-1:0] aluop_out,
   output logic [CTRL_W-1:0]  ctrl_out,
   output logic [RA_W-1:0]    rd_out,
   output logic [15:0]        flush_cnt
);

   // Control fields sit in the low bits so a flush can clear them without touching the datapath
   localparam int CL_W = 1 + ALUOP_W + CTRL_W;
   localparam int PL_W = 4 * XLEN + RA_W + CL_W;

   logic [PL_W-1:0] w_in_pl;
   logic [PL_W-1:0] r_main;
   logic            r_out_valid;
   logic [15:0]     r_flush_cnt;
   logic            w_accept;
   logic            w_consume;
   logic [1:0]      w_drop;
   logic [16:0]     w_cnt_sum;

   assign w_in_pl   = {pc4_in, rd1_in, rd2_in, imm_in, rd_in, alusrc_in, aluop_in, ctrl_in};
   assign w_consume = r_out_valid & out_ready;
   // in_ready already carries rst_n, so nothing is taken during reset
   assign w_accept  = in_valid & in_ready & ~flush;

`ifdef ID_EX_PIPE_SKID_EN
   logic            r_skid_valid;
   logic [PL_W-1:0] r_skid;

   // Ready depends only on registered skid occupancy, never on out_ready
   assign in_ready = rst_n & ~r_skid_valid;
   // Main entry is discarded unless EX takes it this edge; skid entry is always discarded
   assign w_drop   = {1'b0, r_out_valid & ~out_ready} + {1'b0, r_skid_valid};

   // Main/skid occupancy: skid absorbs one accept while EX is stalled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main       <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_out_valid        <= 1'b0;
         r_skid_valid       <= 1'b0;
         r_main[CL_W-1:0]   <= '0;
      end else if (r_skid_valid) begin
         if (w_consume) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
         end
      end else if (w_accept) begin
         if (!r_out_valid || w_consume) begin
            r_main      <= w_in_pl;
            r_out_valid <= 1'b1;
         end else begin
            r_skid       <= w_in_pl;
            r_skid_valid <= 1'b1;
         end
      end else if (w_consume) begin
         r_out_valid <= 1'b0;
      end
   end
`else
   // Without a skid entry the stage can only take new data when the current one leaves
   assign in_ready = rst_n & (out_ready | ~r_out_valid);
   assign w_drop   = {1'b0, r_out_valid & ~out_ready};

   // Single main register: load on accept, empty on consume-only
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_main      <= '0;
      end else if (flush) begin
         r_out_valid      <= 1'b0;
         r_main[CL_W-1:0] <= '0;
      end else if (w_accept) begin
         r_main      <= w_in_pl;
         r_out_valid <= 1'b1;
      end else if (w_consume) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   assign w_cnt_sum = {1'b0, r_flush_cnt} + {15'd0, w_drop};

   // Saturating tally of entries thrown away by flush
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flush_cnt <= 16'd0;
      end else if (flush) begin
         r_flush_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      end
   end

   assign {pc4_out, a_out, b_out, imm_out, rd_out, alusrc_out, aluop_out, ctrl_out} = r_main;
   assign out_valid = r_out_valid;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - randomized queue-model bench for id_ex_pipe
module tb_id_ex_pipe;

`ifdef ID_EX_PIPE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic        alusrc;
      logic [3:0]  aluop;
      logic [7:0]  ctrl;
      logic [4:0]  rd;
   } pl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   pl_t         din = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] pc4_out;
   logic [31:0] a_out;
   logic [31:0] b_out;
   logic [31:0] imm_out;
   logic        alusrc_out;
   logic [3:0]  aluop_out;
   logic [7:0]  ctrl_out;
   logic [4:0]  rd_out;
   logic [15:0] flush_cnt;

   pl_t q[$];
   pl_t shown = '0;
   int  m_cnt = 0;
   int  n_cmp = 0;
   int  n_err = 0;

   id_ex_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .pc4_in(din.pc4), .rd1_in(din.a), .rd2_in(din.b), .imm_in(din.imm),
      .alusrc_in(din.alusrc), .aluop_in(din.aluop), .ctrl_in(din.ctrl), .rd_in(din.rd),
      .pc4_out(pc4_out), .a_out(a_out), .b_out(b_out), .imm_out(imm_out),
      .alusrc_out(alusrc_out), .aluop_out(aluop_out), .ctrl_out(ctrl_out), .rd_out(rd_out),
      .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // One clock: drive at negedge, check ready, advance the queue model at posedge, check outputs
   task automatic step(input logic r, input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] pc4);
      logic exp_rdy;
      logic acc;
      logic con;
      int   drop;
      @(negedge clk);
      rst_n      = r;
      in_valid   = iv;
      out_ready  = ordy;
      flush      = fl;
      din.pc4    = pc4;
      din.a      = $urandom;
      din.b      = $urandom;
      din.imm    = $urandom;
      din.alusrc = 1'($urandom);
      din.aluop  = 4'($urandom);
      din.ctrl   = 8'($urandom);
      din.rd     = 5'($urandom);
      #1;
      exp_rdy = r && ((q.size() < DEPTH) || (DEPTH == 1 && ordy));
      chk("in_ready", in_ready, exp_rdy);
      con = (q.size() > 0) && ordy;
      acc = iv && exp_rdy && !fl;
      @(posedge clk);
      if (!r) begin
         q.delete();
         shown = '0;
         m_cnt = 0;
      end else if (fl) begin
         drop  = q.size() - (con ? 1 : 0);
         m_cnt = (m_cnt + drop > 32'hFFFF) ? 32'hFFFF : m_cnt + drop;
         q.delete();
         shown.alusrc = 1'b0;
         shown.aluop  = 4'd0;
         shown.ctrl   = 8'd0;
      end else begin
         if (con) void'(q.pop_front());
         if (acc) q.push_back(din);
         if (q.size() > 0) shown = q[0];
      end
      #1;
      chk("out_valid",  out_valid,  q.size() > 0);
      chk("pc4_out",    pc4_out,    shown.pc4);
      chk("a_out",      a_out,      shown.a);
      chk("b_out",      b_out,      shown.b);
      chk("imm_out",    imm_out,    shown.imm);
      chk("alusrc_out", alusrc_out, shown.alusrc);
      chk("aluop_out",  aluop_out,  shown.aluop);
      chk("ctrl_out",   ctrl_out,   shown.ctrl);
      chk("rd_out",     rd_out,     shown.rd);
      chk("flush_cnt",  flush_cnt,  m_cnt);
   endtask

   initial begin
      // reset held two cycles with valid input offered
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h44);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h48);
      // streaming 0x04..0x20 back-to-back
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'(i * 4));
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      // back-pressure then drain
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h14);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h18);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h1C);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      // flush while stalled, with a competing input
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h24);
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h28);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      // flush coinciding with a consume
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h30);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h34);
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      // reset beats flush and accept
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h50);
      // randomized traffic
      repeat (3000) begin
         step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom);
      end
      // saturation: preload counter near the top, then keep flushing full stages
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      force dut.r_flush_cnt = 16'hFFFD;
      @(negedge clk);
      release dut.r_flush_cnt;
      m_cnt = 32'hFFFD;
      repeat (4) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
         step(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
         step(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
      end
      chk("flush_cnt_sat", flush_cnt, 16'hFFFF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
